data_mem_arbiter: RTL

Two-port arbiter and sequencer placed in front of the single-port 16x32 data memory. It lets two requesters share the memory: port A (processor load/store path) and port B (loader/debug path). Each transfer uses a registered request/grant handshake. Reads return one cycle after the access cycle, matching the memory's registered read.

---
 rtl/data_mem_arbiter_if.sv | 48 ++++
 rtl/data_mem_arbiter.sv | 115 +++++++++++
 2 files changed

// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if: request/grant handshake for ports A and B plus the
// memory-side bus of the single-port 16x32 data memory.
// The slave modport is the arbiter view. The master modport is the view of the
// requesters and the memory model.
interface data_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt;
    logic              a_rvalid;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt;
    logic              b_rvalid;

    logic [DATA_W-1:0] rdata;
    logic              busy;

    logic [ADDR_W-1:0] mem_address;
    logic              mem_writeEnable;
    logic [DATA_W-1:0] mem_writeData;
    logic [DATA_W-1:0] mem_data;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  mem_data,
        output a_gnt, a_rvalid, b_gnt, b_rvalid,
        output rdata, busy,
        output mem_address, mem_writeEnable, mem_writeData
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output mem_data,
        input  a_gnt, a_rvalid, b_gnt, b_rvalid,
        input  rdata, busy,
        input  mem_address, mem_writeEnable, mem_writeData
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-port (A/B) arbiter and sequencer in front of the
// single-port data memory. Each transfer runs IDLE -> ACCESS (-> RESP for reads).
// Optional feature macro DMEM_ARB_RR_EN:
//   defined   -> round-robin between A and B
//   undefined -> fixed priority, where A always beats B
module data_mem_arbiter #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    data_mem_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;

    // r_last_b is the most recently granted port (1 = B).
    // It also identifies the owner of the transfer in flight.
    logic              r_last_b;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_any_req;
    logic              w_pick_b;
    logic              w_a_gnt;
    logic              w_b_gnt;
    logic              w_a_rvalid;
    logic              w_b_rvalid;
    logic              w_mem_we;

    assign w_any_req = bus.a_req | bus.b_req;

`ifdef DMEM_ARB_RR_EN
    // On a tie, the port that was not granted last wins.
    assign w_pick_b = bus.b_req & (~bus.a_req | ~r_last_b);
`else
    // Fixed priority: B wins only when A is not requesting.
    assign w_pick_b = bus.b_req & ~bus.a_req;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: ACCESS and RESP each last exactly one cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_any_req) w_next = S_ACCESS;
            S_ACCESS: w_next = r_we ? S_IDLE : S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Latch the winner and its command when a request is accepted in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_b <= 1'b1;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else if (r_state == S_IDLE && w_any_req) begin
            r_last_b <= w_pick_b;
            r_we     <= w_pick_b ? bus.b_we    : bus.a_we;
            r_addr   <= w_pick_b ? bus.b_addr  : bus.a_addr;
            r_wdata  <= w_pick_b ? bus.b_wdata : bus.a_wdata;
        end
    end

    // Output decode. The write enable derives from state, so reset kills it at once.
    always_comb begin
        w_a_gnt    = 1'b0;
        w_b_gnt    = 1'b0;
        w_a_rvalid = 1'b0;
        w_b_rvalid = 1'b0;
        w_mem_we   = 1'b0;
        case (r_state)
            S_ACCESS: begin
                w_a_gnt  = ~r_last_b;
                w_b_gnt  = r_last_b;
                w_mem_we = r_we;
            end
            S_RESP: begin
                w_a_rvalid = ~r_last_b;
                w_b_rvalid = r_last_b;
            end
            default: ;
        endcase
    end

    assign bus.a_gnt           = w_a_gnt;
    assign bus.b_gnt           = w_b_gnt;
    assign bus.a_rvalid        = w_a_rvalid;
    assign bus.b_rvalid        = w_b_rvalid;
    assign bus.busy            = (r_state != S_IDLE);
    assign bus.rdata           = bus.mem_data;
    assign bus.mem_address     = r_addr;
    assign bus.mem_writeData   = r_wdata;
    assign bus.mem_writeEnable = w_mem_we;

endmodule
